// File: rtl/if_id_elastic_reg_if.sv
// Handshake bundle between IF and ID through the elastic register.
// slave is the register's view, master is the view of the IF/ID pair around it.
interface if_id_elastic_reg_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [ILEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/if_id_elastic_reg.sv
// IF/ID pipeline register: two-entry skid buffer with flush-to-bubble and a
// saturating stall counter.
//
// state | meaning
// EMPTY | nothing buffered, outputs show the NOP bubble
// ONE   | main entry valid, skid free
// FULL  | main and skid valid, input blocked
module if_id_elastic_reg #(
  parameter int             XLEN      = 32,
  parameter int             ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int             CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  if_id_elastic_reg_if.slave  bus,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] main_pc;
  logic [ILEN-1:0] main_instr;
  logic [XLEN-1:0] skid_pc;
  logic [ILEN-1:0] skid_instr;
  logic            in_fire;
  logic            stall_inc;

  // in_ready depends on registered state and rst only, never on out_ready
  assign bus.in_ready  = (state != FULL) & ~rst;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_pc    = bus.out_valid ? main_pc    : '0;
  assign bus.out_instr = bus.out_valid ? main_instr : NOP_INSTR;

  assign in_fire   = bus.in_valid & bus.in_ready;
  assign stall_inc = bus.out_valid & ~bus.out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
      stall_cnt  <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        state <= EMPTY;
      end else begin
        unique case (state)
          EMPTY: begin
            if (in_fire) begin
              state      <= ONE;
              main_pc    <= bus.in_pc;
              main_instr <= bus.in_instr;
            end
          end
          ONE: begin
            if (in_fire && bus.out_ready) begin
              main_pc    <= bus.in_pc;
              main_instr <= bus.in_instr;
            end else if (in_fire) begin
              state      <= FULL;
              skid_pc    <= bus.in_pc;
              skid_instr <= bus.in_instr;
            end else if (bus.out_ready) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (bus.out_ready) begin
              state      <= ONE;
              main_pc    <= skid_pc;
              main_instr <= skid_instr;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_elastic_reg.sv
// Directed bench for if_id_elastic_reg: accepted entries go into a scoreboard
// queue and a negedge monitor pops and compares every out_fire.
module tb_if_id_elastic_reg;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int CNT_W = 4;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [CNT_W-1:0] stall_cnt;

  if_id_elastic_reg_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  if_id_elastic_reg #(
    .XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fires    = 0;
  logic [XLEN+ILEN-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard/monitor: inputs change only just after posedge, so negedge
  // values are what the next rising edge will see.
  logic            hold_pending = 1'b0;
  logic [XLEN-1:0] hold_pc;
  logic [ILEN-1:0] hold_instr;
  always @(negedge clk) begin
    logic [XLEN+ILEN-1:0] e;
    if (hold_pending && bus.out_valid) begin
      chk("hold_pc", 64'(bus.out_pc), 64'(hold_pc));
      chk("hold_instr", 64'(bus.out_instr), 64'(hold_instr));
    end
    if (!bus.out_valid) begin
      chk("bubble_pc", 64'(bus.out_pc), 64'd0);
      chk("bubble_instr", 64'(bus.out_instr), 64'(NOP));
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      fires++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output_pc", 64'(bus.out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", 64'(bus.out_pc), 64'(e[XLEN+ILEN-1:ILEN]));
        chk("out_instr", 64'(bus.out_instr), 64'(e[ILEN-1:0]));
      end
    end
    if (rst || flush) exp_q.delete();
    else if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.in_pc, bus.in_instr});
    hold_pending = !rst && !flush && bus.out_valid && !bus.out_ready;
    hold_pc      = bus.out_pc;
    hold_instr   = bus.out_instr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = ins;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 32'hBEEF);

    // Reset
    tick(); tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'h13);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Streaming
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'hA0 + 32'(i));
      tick();
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_pc", 64'(bus.out_pc), 64'(4 * i));
      chk("stream_instr", 64'(bus.out_instr), 64'hA0 + 64'(i));
    end
    drive(1'b0, '0, '0);
    tick();
    chk("stream_drain_valid", 64'(bus.out_valid), 64'd0);
    chk("stream_fires", 64'(fires), 64'd4);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hB0); tick();
    chk("bp_one_pc", 64'(bus.out_pc), 64'h100);
    chk("bp_one_in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'h104, 32'hB1); tick();
    chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_full_pc", 64'(bus.out_pc), 64'h100);
    chk("bp_stall1", 64'(stall_cnt), 64'd1);
    drive(1'b1, 32'h108, 32'hB2);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_held_pc", 64'(bus.out_pc), 64'h100);
    chk("bp_held_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_stall4", 64'(stall_cnt), 64'd4);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_rel_pc1", 64'(bus.out_pc), 64'h104);
    tick();
    chk("bp_rel_pc2", 64'(bus.out_pc), 64'h108);
    drive(1'b0, '0, '0);
    tick();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);
    chk("bp_fires", 64'(fires), 64'd7);
    chk("bp_stall_final", 64'(stall_cnt), 64'd4);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Flush when FULL, with an incoming entry that must be dropped
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'hD0); tick();
    drive(1'b1, 32'h204, 32'hD1); tick();
    chk("fl_full_in_ready", 64'(bus.in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h300, 32'hE0); tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_out_instr", 64'(bus.out_instr), 64'h13);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    chk("fl_stall", 64'(stall_cnt), 64'd5);
    tick();
    chk("fl_no_300", 64'(bus.out_valid), 64'd0);

    // Flush cycle with an out_fire, then refill
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h3F0, 32'hF0); tick();
    flush = 1'b1;
    drive(1'b0, '0, '0); tick();
    flush = 1'b0;
    chk("rf_fires", 64'(fires), 64'd8);
    chk("rf_bubble", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 32'h400, 32'hC0); tick();
    chk("rf_valid", 64'(bus.out_valid), 64'd1);
    chk("rf_pc", 64'(bus.out_pc), 64'h400);
    drive(1'b0, '0, '0); tick();
    chk("rf_drained", 64'(bus.out_valid), 64'd0);

    // Saturation
    rst = 1'b1; tick(); rst = 1'b0;
    chk("sat_cleared", 64'(stall_cnt), 64'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h50); tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 64'(stall_cnt), 64'd14);
    tick();
    chk("sat_15", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 64'(stall_cnt), 64'd15);
    bus.out_ready = 1'b1;
    tick();
    chk("sat_after_ready", 64'(stall_cnt), 64'd15);
    chk("sat_consumed", 64'(bus.out_valid), 64'd0);

    // Reset mid-operation while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h600, 32'h60); tick();
    drive(1'b1, 32'h604, 32'h61); tick();
    rst = 1'b1;
    drive(1'b0, '0, '0); tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("mid_rst_no_stale", 64'(bus.out_valid), 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/if_id_elastic_reg.md
Name: if_id_elastic_reg

Overview:
- Parametrised IF/ID pipeline register with valid/ready handshakes on both sides.
- Two-entry skid buffer, so IF can stream one instruction per cycle with no combinational path from out_ready to in_ready.
- Adds a flush with NOP bubble injection for branch/jump redirect, and a saturating stall counter for performance monitoring.
- Sits between the fetch unit and the decode stage.

Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction width in bits.
- NOP_INSTR, 32'h0000_0013, instruction presented when the output is invalid (RV32I ADDI x0,x0,0); width ILEN.
- CNT_W, 16, stall counter width; minimum 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered and incoming entries this cycle.
- in_valid  in  1  IF presents a valid pc/instr.
- in_ready  out  1  register can accept an entry.
- in_pc  in  XLEN  PC from IF.
- in_instr  in  ILEN  instruction from IF.
- out_valid  out  1  entry presented to ID.
- out_ready  in  1  ID consumes the entry this cycle.
- out_pc  out  XLEN  PC to ID.
- out_instr  out  ILEN  instruction to ID.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset is clk and rst only: synchronous, active-high.
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry; registered state EMPTY / ONE / FULL.
- Handshake signals:
  - in_ready = (state != FULL) & ~rst. It is a function of registered state only and never depends on out_ready.
  - out_valid = (state != EMPTY).
  - Once out_valid is 1, out_pc/out_instr must stay stable until out_fire.
- Output values when out_valid=0: out_pc = 0 and out_instr = NOP_INSTR. Otherwise the outputs show the main entry.
- Latency: an entry accepted at edge N appears at out_* after edge N. Minimum latency is 1 cycle; throughput is 1 entry per cycle.
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE:
    - in_fire & out_ready -> ONE, main<=in.
    - in_fire & ~out_ready -> FULL, skid<=in.
    - ~in_fire & out_ready -> EMPTY.
    - Otherwise hold.
  - FULL (in_ready=0):
    - out_ready -> ONE, main<=skid.
    - Otherwise hold.
- Ordering: entries leave strictly in acceptance order; no entry is duplicated or lost except by flush.
- Flush:
  - flush=1 forces next state EMPTY regardless of the current state, in_valid or out_ready.
  - Any input presented in that cycle is discarded, even if in_ready=1 (IF must treat it as dropped).
  - An out_fire in the flush cycle still counts as consumed by ID.
  - The cycle after flush: out_valid=0, out_instr=NOP_INSTR, in_ready=1.
- Priority: rst > flush > handshake.
- Stall counter:
  - Increments by 1 on every edge where out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by rst.
- Reset values (register outputs): state EMPTY, out_valid=0, out_pc=0, out_instr=NOP_INSTR, stall_cnt=0. in_ready=0 while rst is high and 1 the first cycle after.
- Reset mid-operation: all buffered entries are lost; no partial transfers.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0; out_valid=0, out_pc=0, out_instr=32'h13, stall_cnt=0; first cycle after reset in_ready=1.
- Streaming: out_ready=1; send pc 0x0,0x4,0x8,0xC with instr 0xA0..0xA3 back-to-back -> each appears 1 cycle later in order, 4 consecutive out_fire, stall_cnt=0.
- Backpressure: out_ready=0; send pc 0x100 then 0x104 -> state FULL, in_ready=0, out_pc holds 0x100. A third entry 0x108 is held by IF. Raise out_ready -> outputs 0x100, 0x104, 0x108 in order; stall_cnt equals the number of stalled cycles.
- Flush when FULL: with entries 0x200,0x204 buffered, assert flush plus in_valid (pc 0x300) -> next cycle out_valid=0, out_instr=0x13, in_ready=1; 0x300 never appears at the output.
- Flush/refill: flush one cycle, then in_valid pc 0x400 next cycle -> 0x400 is output 1 cycle later with no stale data before it.
- Saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15; unchanged after out_ready returns; cleared by rst.
